// File: rtl/hazard_control_if.sv
// hazard_control_if: ID/EX/MEM hazard inputs and pipeline-register controls of the hazard sequencer
interface hazard_control_if #(parameter int CNT_WIDTH = 16);
  logic [4:0] registerRsID, registerRtID, registerRdEX, registerRdMEM;
  logic useRsID, useRtID, branchID, branchTaken, jumpID;
  logic memReadEX, regWriteEX, memReadMEM;
  logic pcWrite, ifIdWrite, idExBubble, ifIdFlush, stalling;
  logic [CNT_WIDTH-1:0] stallCycles, flushCount;
  modport master (
    output registerRsID, registerRtID, useRsID, useRtID, branchID, branchTaken, jumpID,
           memReadEX, regWriteEX, registerRdEX, memReadMEM, registerRdMEM,
    input  pcWrite, ifIdWrite, idExBubble, ifIdFlush, stalling, stallCycles, flushCount
  );
  modport slave (
    input  registerRsID, registerRtID, useRsID, useRtID, branchID, branchTaken, jumpID,
           memReadEX, regWriteEX, registerRdEX, memReadMEM, registerRdMEM,
    output pcWrite, ifIdWrite, idExBubble, ifIdFlush, stalling, stallCycles, flushCount
  );
endinterface

// File: rtl/hazard_control.sv
// hazard_control: load-use/branch-operand stall sequencer with IF/ID flush and saturating perf counters
module hazard_control #(parameter int CNT_WIDTH = 16) (
  input logic clock,
  input logic reset,
  hazard_control_if.slave hz
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state_q, state_d;
  logic [1:0] rem_q, rem_d, need;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic ex_hit, mem_hit;
  always_comb begin
    ex_hit = (hz.useRsID && hz.registerRsID != 5'd0 && hz.registerRdEX == hz.registerRsID) ||
             (hz.useRtID && hz.registerRtID != 5'd0 && hz.registerRdEX == hz.registerRtID);
    mem_hit = (hz.useRsID && hz.registerRsID != 5'd0 && hz.registerRdMEM == hz.registerRsID) ||
              (hz.useRtID && hz.registerRtID != 5'd0 && hz.registerRdMEM == hz.registerRtID);
    // Priority order matters: a loaded branch operand needs the extra MEM-stage bubble
    need = (hz.branchID && hz.memReadEX && ex_hit) ? 2'd2 :
           (hz.memReadEX && ex_hit) ? 2'd1 :
           (hz.branchID && hz.regWriteEX && ex_hit) ? 2'd1 :
           (hz.branchID && hz.memReadMEM && mem_hit) ? 2'd1 : 2'd0;
  end
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    hz.pcWrite = 1'b1;
    hz.ifIdWrite = 1'b1;
    hz.idExBubble = 1'b0;
    hz.ifIdFlush = 1'b0;
    if (reset) begin
      hz.pcWrite = 1'b0;
      hz.ifIdWrite = 1'b0;
      hz.idExBubble = 1'b1;
      hz.ifIdFlush = 1'b1;
    end else if (state_q == STALL) begin
      hz.pcWrite = 1'b0;
      hz.ifIdWrite = 1'b0;
      hz.idExBubble = 1'b1;
      rem_d = rem_q - 2'd1;
      state_d = (rem_q == 2'd1) ? RUN : STALL;
    end else if (need != 2'd0) begin
      hz.pcWrite = 1'b0;
      hz.ifIdWrite = 1'b0;
      hz.idExBubble = 1'b1;
      rem_d = need - 2'd1;
      state_d = (need > 2'd1) ? STALL : RUN;
    end else begin
      hz.ifIdFlush = (hz.branchID && hz.branchTaken) || hz.jumpID;
    end
    stall_cnt_d = (hz.idExBubble && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (hz.ifIdFlush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rem_q <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign hz.stalling = (state_q == STALL);
  assign hz.stallCycles = stall_cnt_q;
  assign hz.flushCount = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed scenarios for the hazard sequencer with hand-computed expectations
module tb_hazard_control;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  hazard_control_if #(.CNT_WIDTH(16)) hz ();
  hazard_control #(.CNT_WIDTH(16)) dut (.clock(clock), .reset(reset), .hz(hz));
  always #5 clock = ~clock;
  // {pcWrite, ifIdWrite, idExBubble, ifIdFlush, stalling}
  wire [4:0] ctl = {hz.pcWrite, hz.ifIdWrite, hz.idExBubble, hz.ifIdFlush, hz.stalling};
  task automatic idle();
    hz.registerRsID = 5'd0; hz.registerRtID = 5'd0; hz.useRsID = 1'b0; hz.useRtID = 1'b0;
    hz.branchID = 1'b0; hz.branchTaken = 1'b0; hz.jumpID = 1'b0;
    hz.memReadEX = 1'b0; hz.regWriteEX = 1'b0; hz.registerRdEX = 5'd0;
    hz.memReadMEM = 1'b0; hz.registerRdMEM = 5'd0;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    #1;
    n_checks++;
    if (ctl !== 5'b00110) begin n_fail++; $display("FAIL reset_ctl: got %b expected 00110", ctl); end
    n_checks++;
    if ({hz.stallCycles, hz.flushCount} !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", {hz.stallCycles, hz.flushCount}); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL release_ctl: got %b expected 11000", ctl); end
  endtask
  task automatic test_load_use();
    do_reset();
    hz.memReadEX = 1'b1; hz.regWriteEX = 1'b1; hz.registerRdEX = 5'd2;
    hz.useRsID = 1'b1; hz.registerRsID = 5'd2;
    #1;
    n_checks++;
    if (ctl !== 5'b00100) begin n_fail++; $display("FAIL load_use_t: got %b expected 00100", ctl); end
    step();
    hz.memReadEX = 1'b0; hz.regWriteEX = 1'b0; hz.registerRdEX = 5'd0;
    hz.memReadMEM = 1'b1; hz.registerRdMEM = 5'd2;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL load_use_t1: got %b expected 11000", ctl); end
    step();
    idle();
    n_checks++;
    if (hz.stallCycles !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d expected 1", hz.stallCycles); end
  endtask
  task automatic test_load_branch();
    do_reset();
    hz.memReadEX = 1'b1; hz.registerRdEX = 5'd3;
    hz.branchID = 1'b1; hz.branchTaken = 1'b1; hz.useRtID = 1'b1; hz.registerRtID = 5'd3;
    #1;
    n_checks++;
    if (ctl !== 5'b00100) begin n_fail++; $display("FAIL ld_br_t: got %b expected 00100", ctl); end
    step();
    hz.memReadEX = 1'b0; hz.registerRdEX = 5'd0; hz.memReadMEM = 1'b1; hz.registerRdMEM = 5'd3;
    #1;
    n_checks++;
    if (ctl !== 5'b00101) begin n_fail++; $display("FAIL ld_br_t1: got %b expected 00101", ctl); end
    step();
    hz.memReadMEM = 1'b0; hz.registerRdMEM = 5'd0;
    #1;
    n_checks++;
    if (ctl !== 5'b11010) begin n_fail++; $display("FAIL ld_br_t2: got %b expected 11010", ctl); end
    step();
    idle();
    n_checks++;
    if ({hz.stallCycles, hz.flushCount} !== {16'd2, 16'd1}) begin n_fail++; $display("FAIL ld_br_cnt: got %h expected 00020001", {hz.stallCycles, hz.flushCount}); end
  endtask
  task automatic test_alu_branch();
    do_reset();
    hz.regWriteEX = 1'b1; hz.registerRdEX = 5'd4;
    hz.branchID = 1'b1; hz.useRsID = 1'b1; hz.registerRsID = 5'd4;
    #1;
    n_checks++;
    if (ctl !== 5'b00100) begin n_fail++; $display("FAIL alu_br_t: got %b expected 00100", ctl); end
    step();
    hz.regWriteEX = 1'b0; hz.registerRdEX = 5'd0; hz.registerRdMEM = 5'd4;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL alu_br_t1: got %b expected 11000", ctl); end
    step();
    idle();
    n_checks++;
    if (hz.stallCycles !== 16'd1) begin n_fail++; $display("FAIL alu_br_cnt: got %0d expected 1", hz.stallCycles); end
  endtask
  task automatic test_no_stall_cases();
    do_reset();
    hz.regWriteEX = 1'b1; hz.registerRdEX = 5'd4; hz.useRsID = 1'b1; hz.registerRsID = 5'd4;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL alu_nonbr: got %b expected 11000", ctl); end
    idle();
    hz.memReadEX = 1'b1; hz.registerRdEX = 5'd0; hz.useRsID = 1'b1; hz.registerRsID = 5'd0;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL zero_reg: got %b expected 11000", ctl); end
    idle();
    hz.memReadEX = 1'b1; hz.registerRdEX = 5'd6; hz.registerRsID = 5'd6;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL unused_rs: got %b expected 11000", ctl); end
    step();
    idle();
    n_checks++;
    if (hz.stallCycles !== 16'd0) begin n_fail++; $display("FAIL no_stall_cnt: got %0d expected 0", hz.stallCycles); end
  endtask
  task automatic test_mem_branch();
    do_reset();
    hz.memReadMEM = 1'b1; hz.registerRdMEM = 5'd5;
    hz.branchID = 1'b1; hz.useRtID = 1'b1; hz.registerRtID = 5'd5;
    #1;
    n_checks++;
    if (ctl !== 5'b00100) begin n_fail++; $display("FAIL mem_br_t: got %b expected 00100", ctl); end
    step();
    hz.memReadMEM = 1'b0; hz.registerRdMEM = 5'd0;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL mem_br_t1: got %b expected 11000", ctl); end
    idle();
  endtask
  task automatic test_jump();
    do_reset();
    hz.jumpID = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 5'b11010) begin n_fail++; $display("FAIL jump: got %b expected 11010", ctl); end
    step();
    idle();
    n_checks++;
    if ({hz.stallCycles, hz.flushCount} !== {16'd0, 16'd1}) begin n_fail++; $display("FAIL jump_cnt: got %h expected 00000001", {hz.stallCycles, hz.flushCount}); end
  endtask
  task automatic test_reset_mid_stall();
    do_reset();
    hz.memReadEX = 1'b1; hz.registerRdEX = 5'd3;
    hz.branchID = 1'b1; hz.branchTaken = 1'b1; hz.useRsID = 1'b1; hz.registerRsID = 5'd3;
    step();
    n_checks++;
    if (ctl !== 5'b00101) begin n_fail++; $display("FAIL mid_stall_pre: got %b expected 00101", ctl); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 5'b00110) begin n_fail++; $display("FAIL mid_stall_rst: got %b expected 00110", ctl); end
    n_checks++;
    if (hz.stallCycles !== 16'd0) begin n_fail++; $display("FAIL mid_stall_cnt: got %0d expected 0", hz.stallCycles); end
    idle();
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 5'b11000) begin n_fail++; $display("FAIL mid_stall_rel: got %b expected 11000", ctl); end
    n_checks++;
    if ({hz.stallCycles, hz.flushCount} !== 32'd0) begin n_fail++; $display("FAIL mid_stall_relcnt: got %h expected 0", {hz.stallCycles, hz.flushCount}); end
  endtask
  task automatic test_saturation();
    do_reset();
    hz.memReadEX = 1'b1; hz.registerRdEX = 5'd7; hz.useRtID = 1'b1; hz.registerRtID = 5'd7;
    repeat (65534) @(posedge clock);
    #1;
    n_checks++;
    if (hz.stallCycles !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h expected FFFE", hz.stallCycles); end
    repeat (3) step();
    n_checks++;
    if (hz.stallCycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected FFFF", hz.stallCycles); end
    n_checks++;
    if (hz.flushCount !== 16'd0) begin n_fail++; $display("FAIL sat_flush: got %h expected 0", hz.flushCount); end
    idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_no_stall_cases();
    test_mem_branch();
    test_jump();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
